// File: rtl/mem_noc_responder_pkg.sv
// Shared NOC definitions for the memory responder: packet layout, type codes
// and FSM state encoding.
package mem_noc_responder_pkg;

  localparam int NOC_DAT_W = 184;

  // New packet type codes go here.
  localparam logic [7:0] memory_read_request  = 8'h01;
  localparam logic [7:0] memory_read_reply    = 8'h02;
  localparam logic [7:0] memory_write_request = 8'h03;
  localparam logic [7:0] memory_write_reply   = 8'h04;

  typedef struct packed {
    logic [7:0] src_addr;
    logic [3:0] src_port;
    logic [7:0] dst_addr;
    logic [3:0] dst_port;
  } noc_hdr_t;

  typedef struct packed {
    noc_hdr_t               hdr;
    logic [NOC_DAT_W-1:0]   dat;
  } noc_packet;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    REPLY
  } resp_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_noc_responder_ram.sv
// Single-port line RAM: MEM_LINES x 128 bits, per-byte write enable and a
// registered read port. Contents are deliberately not reset.
module mem_line_ram #(
  parameter int LINES = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [15:0]      we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [127:0]     wdata_i,
  output logic [127:0]     rdata_o
);

  logic [127:0] mem_q [LINES];
  logic [127:0] rdata_q;

  // Read returns the line as it was before any write in the same cycle.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 16; i++) begin
        if (we_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_noc_responder.sv
// NOC memory responder: accepts one read/write request at a time, accesses
// the line RAM and returns a reply packet with swapped header.
module mem_noc_responder
  import mem_noc_responder_pkg::*;
#(
  parameter int MEM_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rq_av,
  output logic        rq_re,
  input  noc_packet   rq_dat,
  output logic        rp_av,
  input  logic        rp_re,
  output noc_packet   rp_dat,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] err_cnt
);

  localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

  resp_state_e state_q, state_d;
  noc_packet   req_q, req_d;
  noc_packet   rp_q, rp_d;
  logic        rp_av_q, rp_av_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic             ram_en;
  logic [15:0]      ram_we;
  logic [IDX_W-1:0] ram_idx;
  logic [127:0]     ram_rdata;

  logic [7:0]   req_type;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wmask;

  assign req_type  = req_q.dat[7:0];
  assign req_addr  = req_q.dat[8 +: 32];
  assign req_wdata = req_q.dat[40 +: 128];
  assign req_wmask = req_q.dat[168 +: 16];
  // Bits above the line index are ignored, so addresses wrap over the RAM.
  assign ram_idx   = req_addr[4 +: IDX_W];

  mem_line_ram #(
    .LINES (MEM_LINES),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .idx_i   (ram_idx),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rp_d      = rp_q;
    rp_av_d   = rp_av_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    rq_re     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = '0;

    case (state_q)
      IDLE: begin
        rq_re = rq_av;
        if (rq_av) begin
          req_d   = rq_dat;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (req_type == memory_read_request) begin
          ram_en  = 1'b1;
          state_d = WAIT;
        end else if (req_type == memory_write_request) begin
          ram_en  = 1'b1;
          ram_we  = req_wmask;
          state_d = WAIT;
        end else begin
          err_cnt_d = sat_inc(err_cnt_q);
          state_d   = IDLE;
        end
      end
      WAIT: begin
        rp_d = '0;
        rp_d.hdr.src_addr = req_q.hdr.dst_addr;
        rp_d.hdr.src_port = req_q.hdr.dst_port;
        rp_d.hdr.dst_addr = req_q.hdr.src_addr;
        rp_d.hdr.dst_port = req_q.hdr.src_port;
        rp_d.dat[136 +: 32] = req_addr;
        if (req_type == memory_read_request) begin
          rp_d.dat[7:0]     = memory_read_reply;
          rp_d.dat[8 +: 128] = ram_rdata;
        end else begin
          rp_d.dat[7:0] = memory_write_reply;
        end
        rp_av_d = 1'b1;
        state_d = REPLY;
      end
      REPLY: begin
        if (rp_re) begin
          rp_av_d = 1'b0;
          if (req_type == memory_read_request) begin
            rd_cnt_d = sat_inc(rd_cnt_q);
          end else begin
            wr_cnt_d = sat_inc(wr_cnt_q);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset wins over any handshake or RAM access in the same cycle.
    if (rst) begin
      rq_re  = 1'b0;
      ram_en = 1'b0;
      ram_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rp_q      <= '0;
      rp_av_q   <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rp_q      <= rp_d;
      rp_av_q   <= rp_av_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rp_av   = rp_av_q;
  assign rp_dat  = rp_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mem_noc_responder.sv
// Self-checking bench for mem_noc_responder: directed scenarios plus a
// randomized sequence checked against a byte-level memory model.
module tb_mem_noc_responder;
  import mem_noc_responder_pkg::*;

  localparam int MEM_LINES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_av;
  logic        rq_re;
  noc_packet   rq_dat;
  logic        rp_av;
  logic        rp_re;
  noc_packet   rp_dat;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int rd_exp   = 0;
  int wr_exp   = 0;
  int err_exp  = 0;

  logic [7:0] mem_m   [MEM_LINES][16];
  bit         known_m [MEM_LINES][16];

  always #5 clk = ~clk;

  mem_noc_responder #(.MEM_LINES(MEM_LINES)) dut (
    .clk     (clk),
    .rst     (rst),
    .rq_av   (rq_av),
    .rq_re   (rq_re),
    .rq_dat  (rq_dat),
    .rp_av   (rp_av),
    .rp_re   (rp_re),
    .rp_dat  (rp_dat),
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt),
    .err_cnt (err_cnt)
  );

  function automatic noc_packet mk_req(input logic [7:0] typ, input logic [31:0] addr,
                                       input logic [127:0] wdata, input logic [15:0] wmask);
    noc_packet p;
    p.hdr.src_addr = 8'($urandom);
    p.hdr.src_port = 4'($urandom);
    p.hdr.dst_addr = 8'($urandom);
    p.hdr.dst_port = 4'($urandom);
    p.dat = '0;
    p.dat[7:0]      = typ;
    p.dat[8 +: 32]  = addr;
    p.dat[40 +: 128] = wdata;
    p.dat[168 +: 16] = wmask;
    return p;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int line_of(input logic [31:0] addr);
    int unsigned a;
    a = addr;
    return int'((a / 16) % MEM_LINES);
  endfunction

  // Expected reply plus a care mask that hides bytes never written.
  function automatic void model_reply(input noc_packet req, output noc_packet exp_p,
                                      output noc_packet care_p);
    int ln;
    ln = line_of(req.dat[8 +: 32]);
    exp_p  = '0;
    care_p = '1;
    exp_p.hdr.src_addr = req.hdr.dst_addr;
    exp_p.hdr.src_port = req.hdr.dst_port;
    exp_p.hdr.dst_addr = req.hdr.src_addr;
    exp_p.hdr.dst_port = req.hdr.src_port;
    exp_p.dat[136 +: 32] = req.dat[8 +: 32];
    if (req.dat[7:0] == memory_read_request) begin
      exp_p.dat[7:0] = memory_read_reply;
      for (int i = 0; i < 16; i++) begin
        if (known_m[ln][i]) exp_p.dat[8 + 8*i +: 8] = mem_m[ln][i];
        else care_p.dat[8 + 8*i +: 8] = 8'h00;
      end
    end else begin
      exp_p.dat[7:0] = memory_write_reply;
    end
  endfunction

  function automatic void model_write(input noc_packet req);
    int ln;
    ln = line_of(req.dat[8 +: 32]);
    if (req.dat[7:0] == memory_write_request) begin
      for (int i = 0; i < 16; i++) begin
        if (req.dat[168 + i]) begin
          mem_m[ln][i]   = req.dat[40 + 8*i +: 8];
          known_m[ln][i] = 1'b1;
        end
      end
    end
  endfunction

  // Drives a request until the handshake edge; returns one step after it.
  task automatic send_req(input noc_packet p);
    bit done;
    done   = 1'b0;
    rq_dat = p;
    rq_av  = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (rq_re) done = 1'b1;
      @(posedge clk); #1;
    end
    rq_av = 1'b0;
    if (!done) begin
      failures++;
      $display("[TB] FAIL send_req_timeout: rq_re=0 required=1");
    end
  endtask

  // Waits for rp_av, samples the reply, stalls 'hold' cycles, then accepts it.
  task automatic wait_reply(input int hold, output noc_packet p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rp_av) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      failures++;
      $display("[TB] FAIL wait_reply_timeout: rp_av=0 required=1");
    end
    p = rp_dat;
    repeat (hold) begin @(posedge clk); #1; end
    rp_re = 1'b1;
    @(posedge clk); #1;
    rp_re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rq_av = 1'b0; rp_re = 1'b0; rq_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    rq_av = 1'b1;
    #1;
    checks++;
    if (rq_re !== 1'b0) begin failures++; $display("[TB] FAIL reset_rq_re: got=%b want=0", rq_re); end
    checks++;
    if (rp_av !== 1'b0 || rp_dat !== '0) begin
      failures++; $display("[TB] FAIL reset_reply: rp_av=%b rp_dat=%h want 0/0", rp_av, rp_dat);
    end
    checks++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_counters: rd=%0d wr=%0d err=%0d want 0", rd_cnt, wr_cnt, err_cnt);
    end
    rq_av = 1'b0;
    rst = 1'b0;
    rd_exp = 0; wr_exp = 0; err_exp = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    noc_packet w, r, g, e, c;
    logic [127:0] wd;
    logic [127:0] got_line;
    bit bytes_ok;
    for (int i = 0; i < 16; i++) wd[8*i +: 8] = 8'(i);
    w = mk_req(memory_write_request, 32'h20, wd, 16'hFFFF);
    model_reply(w, e, c);
    model_write(w);
    send_req(w);
    checks++;
    if (rp_av !== 1'b0) begin failures++; $display("[TB] FAIL latency_access: rp_av=%b want=0", rp_av); end
    @(posedge clk); #1;
    checks++;
    if (rp_av !== 1'b0) begin failures++; $display("[TB] FAIL latency_wait: rp_av=%b want=0", rp_av); end
    @(posedge clk); #1;
    checks++;
    if (rp_av !== 1'b1) begin failures++; $display("[TB] FAIL latency_reply: rp_av=%b want=1", rp_av); end
    wait_reply(0, g);
    wr_exp++;
    checks++;
    if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL write_reply: got=%h want=%h", g, e); end

    r = mk_req(memory_read_request, 32'h20, rand_line(), 16'($urandom));
    model_reply(r, e, c);
    send_req(r);
    wait_reply(0, g);
    rd_exp++;
    checks++;
    if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL read_reply: got=%h want=%h", g, e); end
    got_line = g.dat[8 +: 128];
    bytes_ok = 1'b1;
    for (int i = 0; i < 16; i++) if (got_line[8*i +: 8] !== 8'(i)) bytes_ok = 1'b0;
    checks++;
    if (!bytes_ok || g.dat[7:0] !== memory_read_reply || g.dat[136 +: 32] !== 32'h20) begin
      failures++; $display("[TB] FAIL read_fields: line=%h type=%h addr=%h", got_line, g.dat[7:0], g.dat[136 +: 32]);
    end
    checks++;
    if (g.hdr.src_addr !== r.hdr.dst_addr || g.hdr.src_port !== r.hdr.dst_port ||
        g.hdr.dst_addr !== r.hdr.src_addr || g.hdr.dst_port !== r.hdr.src_port) begin
      failures++; $display("[TB] FAIL hdr_swap: got=%h req=%h", g.hdr, r.hdr);
    end
    checks++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin
      failures++; $display("[TB] FAIL counts_after_wr_rd: wr=%0d rd=%0d want 1/1", wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_partial_mask();
    noc_packet p, g, e, c;
    logic [127:0] want;
    p = mk_req(memory_write_request, 32'h30, {16{8'h55}}, 16'hFFFF);
    model_write(p); send_req(p); wait_reply(0, g); wr_exp++;
    p = mk_req(memory_write_request, 32'h30, {16{8'hAA}}, 16'h000F);
    model_write(p); send_req(p); wait_reply(1, g); wr_exp++;
    p = mk_req(memory_read_request, 32'h3C, '0, '0);
    model_reply(p, e, c);
    send_req(p); wait_reply(0, g); rd_exp++;
    want = {{12{8'h55}}, {4{8'hAA}}};
    checks++;
    if (g.dat[8 +: 128] !== want) begin
      failures++; $display("[TB] FAIL partial_mask: got=%h want=%h", g.dat[8 +: 128], want);
    end
    checks++;
    if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL partial_reply: got=%h want=%h", g, e); end
  endtask

  task automatic test_backpressure();
    noc_packet r, r2, first, g, e, c;
    r = mk_req(memory_read_request, 32'h20, '0, '0);
    r2 = mk_req(memory_read_request, 32'h30, '0, '0);
    send_req(r);
    repeat (2) begin @(posedge clk); #1; end
    first = rp_dat;
    rq_dat = r2;
    rq_av = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rp_av !== 1'b1 || rp_dat !== first || rq_re !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_cycle%0d: rp_av=%b rq_re=%b rp_dat=%h want 1/0/%h", k, rp_av, rq_re, rp_dat, first);
      end
    end
    rp_re = 1'b1;
    @(posedge clk); #1;
    rp_re = 1'b0;
    rd_exp++;
    model_reply(r, e, c);
    checks++;
    if ((first & c) !== (e & c)) begin failures++; $display("[TB] FAIL stall_reply: got=%h want=%h", first, e); end
    checks++;
    if (rp_av !== 1'b0 || rq_re !== 1'b1) begin
      failures++; $display("[TB] FAIL after_reply: rp_av=%b rq_re=%b want 0/1", rp_av, rq_re);
    end
    model_reply(r2, e, c);
    send_req(r2);
    wait_reply(0, g);
    rd_exp++;
    checks++;
    if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL queued_reply: got=%h want=%h", g, e); end
    checks++;
    if (rd_cnt !== 16'(rd_exp)) begin failures++; $display("[TB] FAIL rd_cnt_stall: got=%0d want=%0d", rd_cnt, rd_exp); end
  endtask

  task automatic test_illegal();
    noc_packet p, g, e, c;
    bit seen;
    p = mk_req(8'hFF, 32'h20, rand_line(), 16'hFFFF);
    send_req(p);
    err_exp++;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rp_av) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("[TB] FAIL illegal_reply: rp_av=1 want=0"); end
    checks++;
    if (err_cnt !== 16'(err_exp)) begin failures++; $display("[TB] FAIL err_cnt: got=%0d want=%0d", err_cnt, err_exp); end
    p = mk_req(memory_read_request, 32'h20, '0, '0);
    model_reply(p, e, c);
    send_req(p); wait_reply(0, g); rd_exp++;
    checks++;
    if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL post_illegal_read: got=%h want=%h", g, e); end
  endtask

  task automatic test_wrap();
    noc_packet p, g, e, c;
    logic [127:0] wd;
    logic [31:0] wa;
    wd = rand_line();
    p = mk_req(memory_write_request, 32'h10, wd, 16'hFFFF);
    model_write(p); send_req(p); wait_reply(0, g); wr_exp++;
    wa = 32'(MEM_LINES * 16 + 16'h10);
    p = mk_req(memory_read_request, wa, '0, '0);
    model_reply(p, e, c);
    send_req(p); wait_reply(2, g); rd_exp++;
    checks++;
    if (g.dat[8 +: 128] !== wd || g.dat[136 +: 32] !== wa) begin
      failures++; $display("[TB] FAIL wrap_read: line=%h addr=%h want %h/%h", g.dat[8 +: 128], g.dat[136 +: 32], wd, wa);
    end
    checks++;
    if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL wrap_reply: got=%h want=%h", g, e); end
  endtask

  task automatic test_random();
    noc_packet p, g, e, c;
    int sel;
    logic [31:0] a;
    logic [7:0] typ;
    bit seen;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) typ = 8'h80 + 8'($urandom_range(0, 127));
      else if (sel < 5) typ = memory_write_request;
      else typ = memory_read_request;
      a = ($urandom & ~32'h0000_03F0) | (32'($urandom_range(0, 7)) << 4);
      p = mk_req(typ, a, rand_line(), 16'($urandom));
      if (sel == 0) begin
        send_req(p);
        err_exp++;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (rp_av) seen = 1'b1; end
        checks++;
        if (seen) begin failures++; $display("[TB] FAIL rand_illegal%0d: rp_av=1 want=0", n); end
      end else begin
        model_reply(p, e, c);
        model_write(p);
        send_req(p);
        wait_reply($urandom_range(0, 3), g);
        if (typ == memory_read_request) rd_exp++; else wr_exp++;
        checks++;
        if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL rand_reply%0d: got=%h want=%h", n, g, e); end
      end
    end
    checks++;
    if (rd_cnt !== 16'(rd_exp) || wr_cnt !== 16'(wr_exp) || err_cnt !== 16'(err_exp)) begin
      failures++;
      $display("[TB] FAIL rand_counters: rd=%0d wr=%0d err=%0d want %0d/%0d/%0d", rd_cnt, wr_cnt, err_cnt, rd_exp, wr_exp, err_exp);
    end
  endtask

  task automatic test_reset_in_reply();
    noc_packet p, g, e, c;
    p = mk_req(memory_read_request, 32'h20, '0, '0);
    send_req(p);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    rp_re = 1'b1;
    @(posedge clk); #1;
    rp_re = 1'b0;
    checks++;
    if (rp_av !== 1'b0 || rp_dat !== '0) begin
      failures++; $display("[TB] FAIL reset_in_reply: rp_av=%b rp_dat=%h want 0/0", rp_av, rp_dat);
    end
    checks++;
    if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_counters2: rd=%0d wr=%0d err=%0d want 0", rd_cnt, wr_cnt, err_cnt);
    end
    rst = 1'b0;
    rd_exp = 0; wr_exp = 0; err_exp = 0;
    p = mk_req(memory_write_request, 32'h40, rand_line(), 16'($urandom));
    model_reply(p, e, c);
    model_write(p);
    send_req(p); wait_reply(0, g); wr_exp++;
    checks++;
    if ((g & c) !== (e & c)) begin failures++; $display("[TB] FAIL post_reset_write: got=%h want=%h", g, e); end
    checks++;
    if (wr_cnt !== 16'd1 || rd_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL post_reset_counts: wr=%0d rd=%0d want 1/0", wr_cnt, rd_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; rq_av = 1'b0; rp_re = 1'b0; rq_dat = '0;
    for (int l = 0; l < MEM_LINES; l++)
      for (int b = 0; b < 16; b++) begin mem_m[l][b] = 8'h00; known_m[l][b] = 1'b0; end
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_partial_mask();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_random();
    test_reset_in_reply();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
